// File: rtl/mem_bank_arb_scrub_if.sv
// Requester-side bus of the bank controller: two request/grant channels plus the shared read response.
// Master = requester side, slave = controller side.
interface mem_bank_arb_scrub_if;
  logic        a_req;
  logic        a_we;
  logic [5:0]  a_addr;
  logic [19:0] a_wdata;
  logic        a_gnt;
  logic        a_rvalid;
  logic        b_req;
  logic        b_we;
  logic [5:0]  b_addr;
  logic [19:0] b_wdata;
  logic        b_gnt;
  logic        b_rvalid;
  logic [19:0] rdata;
  logic        rerr;

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, rerr
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, rerr
  );
endinterface

// File: rtl/mem_bank_arb_scrub.sv
// Round-robin two-requester front end for a 64x20 ECC bank with a background scrubber.
// Optional MEM_ARB_SCRUB_STATS_EN adds saturating sweep_cnt / fix_cnt outputs.
module mem_bank_arb_scrub #(
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_bank_arb_scrub_if.slave   bus,
  output logic                  bank_WE,
  output logic [5:0]            bank_addr,
  output logic [19:0]           bank_in,
  input  logic [19:0]           bank_out,
  input  logic                  bank_err,
  output logic                  scrub_busy,
  output logic                  uncorr,
  input  logic                  uncorr_clr
`ifdef MEM_ARB_SCRUB_STATS_EN
  ,
  output logic [7:0]            sweep_cnt,
  output logic [7:0]            fix_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, SWAIT, SRD, SWR, CHECK} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state;
  logic [5:0]  ptr;
  logic [19:0] hold;
  logic [3:0]  starve;
  logic        last_b;
  logic        any_req;
  logic        starved;
  logic        port_owned;
  logic        port_free;
  logic        gnt_a;
  logic        gnt_b;
  logic        we_int;
  logic [5:0]  addr_int;
  logic [19:0] in_int;
  logic        a_rvalid_q;
  logic        b_rvalid_q;
  logic [19:0] rdata_q;
  logic        rerr_q;

  assign any_req    = bus.a_req | bus.b_req;
  assign starved    = (state == SWAIT) && (starve == STARVE_LIM);
  assign port_owned = (state == SRD) || (state == SWR);
  assign port_free  = !port_owned && !starved;

  // Round robin: with both requesting, the one not served last wins.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (port_free) begin
      if (bus.a_req && (!bus.b_req || last_b)) gnt_a = 1'b1;
      else if (bus.b_req)                      gnt_b = 1'b1;
    end
  end

  always_comb begin
    we_int   = 1'b0;
    addr_int = '0;
    in_int   = '0;
    if (port_owned) begin
      addr_int = ptr;
      in_int   = hold;
      we_int   = (state == SWR);
    end else if (gnt_a) begin
      addr_int = bus.a_addr;
      in_int   = bus.a_wdata;
      we_int   = bus.a_we;
    end else if (gnt_b) begin
      addr_int = bus.b_addr;
      in_int   = bus.b_wdata;
      we_int   = bus.b_we;
    end
  end

  // Combinational outputs are gated so nothing reaches the bank while reset is held.
  assign bank_WE      = rst_n & we_int;
  assign bank_addr    = rst_n ? addr_int : 6'd0;
  assign bank_in      = rst_n ? in_int : 20'd0;
  assign bus.a_gnt    = rst_n & gnt_a;
  assign bus.b_gnt    = rst_n & gnt_b;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.rerr     = rerr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      rdata_q    <= '0;
      rerr_q     <= 1'b0;
      last_b     <= 1'b1;
    end else begin
      a_rvalid_q <= gnt_a & ~bus.a_we;
      b_rvalid_q <= gnt_b & ~bus.b_we;
      if ((gnt_a & ~bus.a_we) | (gnt_b & ~bus.b_we)) begin
        rdata_q <= bank_out;
        rerr_q  <= bank_err;
      end
      if (gnt_a | gnt_b) last_b <= gnt_b;
    end
  end

  // SRD and SWR always run back to back, so no requester write can slip between them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      hold       <= '0;
      starve     <= '0;
      scrub_busy <= 1'b0;
      uncorr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bank_err && !uncorr) begin
            state      <= SWAIT;
            ptr        <= '0;
            starve     <= '0;
            scrub_busy <= 1'b1;
          end
        end
        SWAIT: begin
          if (!any_req || starved) state <= SRD;
          else if (starve != 4'hF) starve <= starve + 4'd1;
        end
        SRD: begin
          hold  <= bank_out;
          state <= SWR;
        end
        SWR: begin
          starve <= '0;
          if (ptr == 6'd63) begin
            state <= CHECK;
          end else begin
            ptr   <= ptr + 6'd1;
            state <= SWAIT;
          end
        end
        CHECK: begin
          ptr        <= '0;
          state      <= IDLE;
          scrub_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          scrub_busy <= 1'b0;
        end
      endcase
      // A failing check outranks a simultaneous clear.
      if ((state == CHECK) && bank_err) uncorr <= 1'b1;
      else if (uncorr_clr)              uncorr <= 1'b0;
    end
  end

`ifdef MEM_ARB_SCRUB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt <= '0;
      fix_cnt   <= '0;
    end else if (state == CHECK) begin
      if (sweep_cnt != 8'hFF)            sweep_cnt <= sweep_cnt + 8'd1;
      if (!bank_err && fix_cnt != 8'hFF) fix_cnt   <= fix_cnt + 8'd1;
    end
  end
`endif

endmodule
